// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned DEF_MEM_TIMEOUT = 64;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one execute-stage source register; M beats W.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding, load-use interlock, branch flush, memory freeze watchdog.
// Optional perf counters (stall_cycles, flush_count) are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic        RegWriteE,
  input  logic        ResultSrcE,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic [4:0]  RD_W,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        mem_req_M,
  input  logic        mem_ack,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_err
);

  localparam logic [15:0] TimeoutLast = 16'(MEM_TIMEOUT - 1);

  hz_state_t   r_state;
  logic [15:0] r_wait_cnt;
  logic        r_mem_err;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_lw_stall;
  logic       w_mem_busy;
  logic       w_branch_flush;

  fwd_select u_fwd_a (
    .i_rs          (RS1_E),
    .i_rd_m        (RD_M),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RD_W),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs          (RS2_E),
    .i_rd_m        (RD_M),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RD_W),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_b)
  );

  assign w_lw_stall = ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                      ((RD_E == RS1_D) | (RD_E == RS2_D));
  assign w_mem_busy = mem_req_M & ~mem_ack & (r_state != ERR);
  assign w_branch_flush = PCSrcE & ~w_mem_busy;

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (rst) begin
      ForwardAE = w_fwd_a;
      ForwardBE = w_fwd_b;
      if (w_mem_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // An ack arriving on the timeout cycle wins; a dropped request also ends the wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 16'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack || !mem_req_M) begin
            r_state    <= RUN;
            r_wait_cnt <= 16'd0;
          end else if (r_wait_cnt >= TimeoutLast) begin
            r_state   <= ERR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        ERR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign mem_err = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (StallF) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_branch_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (instantiated with MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_req_M, mem_ack;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0] sf;
  assign sf = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .RS1_D      (RS1_D),
    .RS2_D      (RS2_D),
    .RS1_E      (RS1_E),
    .RS2_E      (RS2_E),
    .RD_E       (RD_E),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .RD_M       (RD_M),
    .RegWriteM  (RegWriteM),
    .RD_W       (RD_W),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .mem_req_M  (mem_req_M),
    .mem_ack    (mem_ack),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .mem_err    (mem_err)
  );

  task automatic clear_inputs();
    RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0; RD_E = 5'd0;
    RD_M = 5'd0; RD_W = 5'd0;
    RegWriteE = 1'b0; ResultSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; mem_req_M = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    mem_req_M = 1'b1; PCSrcE = 1'b1; RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5; RS2_E = 5'd5;
    #1;
    checks++;
    if (sf !== 6'b000000) begin
      errors++; $display("FAIL reset_stall_flush got=%b exp=%b", sf, 6'b000000);
    end
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      errors++; $display("FAIL reset_fwd got=%b/%b exp=00/00", ForwardAE, ForwardBE);
    end
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0 || dut.r_state !== RUN) begin
      errors++; $display("FAIL reset_state mem_err=%b state=%0d exp 0/RUN", mem_err, dut.r_state);
    end
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1; RS1_E = 5'd5; RS2_E = 5'd5;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_priority got=%b/%b exp=10/10", ForwardAE, ForwardBE);
    end
    RD_M = 5'd0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_rdm_zero got=%b exp=01", ForwardAE);
    end
    RS2_E = 5'd0; RD_W = 5'd0;
    #1;
    checks++;
    if (ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0 got=%b exp=00", ForwardBE);
    end
    RD_M = 5'd9; RegWriteM = 1'b0; RS1_E = 5'd9; RS2_E = 5'd12; RD_W = 5'd12;
    #1;
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_regwrite_gate got=%b/%b exp=00/01", ForwardAE, ForwardBE);
    end
    RegWriteM = 1'b1; RegWriteW = 1'b0;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_independent got=%b/%b exp=10/00", ForwardAE, ForwardBE);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; RS2_D = 5'd7; RS1_D = 5'd3;
    #1;
    checks++;
    if (sf !== 6'b110001) begin
      errors++; $display("FAIL lu_stall got=%b exp=%b", sf, 6'b110001);
    end
    // Load has moved to M, bubble in E.
    @(negedge clk);
    ResultSrcE = 1'b0; RegWriteE = 1'b0; RD_E = 5'd0; RD_M = 5'd7; RegWriteM = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b000000) begin
      errors++; $display("FAIL lu_one_cycle got=%b exp=%b", sf, 6'b000000);
    end
    @(negedge clk);
    clear_inputs();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd0; RS1_D = 5'd0;
    #1;
    checks++;
    if (sf !== 6'b000000) begin
      errors++; $display("FAIL lu_rd_zero got=%b exp=%b", sf, 6'b000000);
    end
    RD_E = 5'd4; RS1_D = 5'd4;
    #1;
    checks++;
    if (sf !== 6'b110001) begin
      errors++; $display("FAIL lu_rs1 got=%b exp=%b", sf, 6'b110001);
    end
    clear_inputs();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    mem_req_M = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (sf !== 6'b111100) begin
        errors++; $display("FAIL freeze_cycle%0d got=%b exp=%b", i, sf, 6'b111100);
      end
      @(negedge clk);
    end
    // Ack coincides with the timeout comparison: ack wins.
    mem_ack = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b000000) begin
      errors++; $display("FAIL freeze_ack_cycle got=%b exp=%b", sf, 6'b000000);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (dut.r_state !== RUN || mem_err !== 1'b0) begin
      errors++; $display("FAIL freeze_back_run state=%0d mem_err=%b exp RUN/0", dut.r_state, mem_err);
    end
  endtask

  task automatic test_priority();
    do_reset();
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; RS2_D = 5'd7; PCSrcE = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b000011) begin
      errors++; $display("FAIL prio_branch_over_lu got=%b exp=%b", sf, 6'b000011);
    end
    mem_req_M = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b111100) begin
      errors++; $display("FAIL prio_mem_over_branch got=%b exp=%b", sf, 6'b111100);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b000011) begin
      errors++; $display("FAIL prio_ack_branch got=%b exp=%b", sf, 6'b000011);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_M = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (sf !== 6'b111100 || mem_err !== 1'b0) begin
        errors++; $display("FAIL to_stall%0d got=%b err=%b exp=%b err=0", i, sf, mem_err, 6'b111100);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (mem_err !== 1'b1 || sf !== 6'b000000) begin
      errors++; $display("FAIL to_err_rise err=%b sf=%b exp err=1 sf=000000", mem_err, sf);
    end
    PCSrcE = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b000011) begin
      errors++; $display("FAIL err_branch got=%b exp=%b", sf, 6'b000011);
    end
    PCSrcE = 1'b0; ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd8; RS1_D = 5'd8;
    RD_W = 5'd2; RegWriteW = 1'b1; RS2_E = 5'd2;
    #1;
    checks++;
    if (sf !== 6'b110001 || ForwardBE !== 2'b01) begin
      errors++; $display("FAIL err_lu_fwd sf=%b fwdB=%b exp 110001/01", sf, ForwardBE);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got=%b exp=1", mem_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0 || sf !== 6'b000000 || ForwardBE !== 2'b00) begin
      errors++; $display("FAIL err_reset err=%b sf=%b fwdB=%b exp 0/000000/00", mem_err, sf, ForwardBE);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req_M = 1'b1; RD_M = 5'd6; RegWriteM = 1'b1; RS1_E = 5'd6;
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (dut.r_state !== MEM_WAIT || sf !== 6'b111100) begin
      errors++; $display("FAIL ar_pre state=%0d sf=%b exp MEM_WAIT/111100", dut.r_state, sf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sf !== 6'b000000 || ForwardAE !== 2'b00 || mem_err !== 1'b0 || dut.r_state !== RUN) begin
      errors++; $display("FAIL ar_mid_wait sf=%b fwdA=%b err=%b state=%0d exp all 0/RUN",
                         sf, ForwardAE, mem_err, dut.r_state);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    mem_req_M = 1'b1;
    #1;
    checks++;
    if (sf !== 6'b111100) begin
      errors++; $display("FAIL ar_first_run got=%b exp=%b", sf, 6'b111100);
    end
    @(negedge clk);
    checks++;
    if (dut.r_state !== MEM_WAIT || dut.r_wait_cnt !== 16'd1) begin
      errors++; $display("FAIL ar_enter_wait state=%0d cnt=%0d exp MEM_WAIT/1",
                         dut.r_state, dut.r_wait_cnt);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    #1;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles, flush_count);
    end
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; RS1_D = 5'd7;
    repeat (10) @(negedge clk);
    clear_inputs();
    PCSrcE = 1'b1;
    repeat (3) @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_cycles !== 32'd10 || flush_count !== 32'd3) begin
      errors++; $display("FAIL perf_count got=%0d/%0d exp=10/3", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_freeze();
    test_priority();
    test_timeout();
    test_async_reset();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
